// File: rtl/cnn_layer_sequencer.sv
// Frame-level sequencer for a two-layer CNN accelerator: loads the image, runs
// layer 1 then layer 2, counts channel completions and guards against stalls.
module cnn_layer_sequencer #(
  parameter int L1_CH    = 8,
  parameter int L2_CH    = 16,
  parameter int LOAD_CYC = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       l1_cout_done,
  input  logic       l1_pool_done,
  input  logic       l2_cout_done,
  input  logic       l2_pool_done,
  output logic       img_load,
  output logic       l1_start,
  output logic       l2_start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] l1_ch,
  output logic [4:0] l2_ch,
  output logic [7:0] frame_cnt
);

  localparam int LC_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, L1_RUN, L2_RUN, DONE, ERR} state_t;

  state_t          state;
  logic [LC_W-1:0] load_cnt;
  logic [WD_W-1:0] wd;

  logic       in_l1, in_l2, act_cout, act_pool, act_full, bad_event, wd_expired;
  logic [4:0] act_ch, act_next, act_target;

  // Both run states share one checker; the inactive layer's events are masked out.
  always_comb begin
    in_l1      = (state == L1_RUN);
    in_l2      = (state == L2_RUN);
    act_cout   = (in_l1 & l1_cout_done) | (in_l2 & l2_cout_done);
    act_pool   = (in_l1 & l1_pool_done) | (in_l2 & l2_pool_done);
    act_ch     = in_l2 ? l2_ch : l1_ch;
    act_target = in_l2 ? 5'(L2_CH) : 5'(L1_CH);
    act_full   = (act_ch == act_target);
    act_next   = act_ch + {4'd0, act_cout};
    bad_event  = (act_cout && act_full) || (act_pool && (act_next != act_target));
    wd_expired = !act_cout && !act_pool && (wd == WD_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      load_cnt  <= '0;
      wd        <= '0;
      img_load  <= 1'b0;
      l1_start  <= 1'b0;
      l2_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      l1_ch     <= '0;
      l2_ch     <= '0;
      frame_cnt <= '0;
    end else begin
      l1_start <= 1'b0;
      l2_start <= 1'b0;
      done     <= 1'b0;
      // Abort outranks every layer event, including ones arriving in the same cycle.
      if (abort && (state != IDLE)) begin
        state    <= IDLE;
        img_load <= 1'b0;
        busy     <= 1'b0;
        err      <= 1'b0;
        l1_ch    <= '0;
        l2_ch    <= '0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            state    <= LOAD;
            img_load <= 1'b1;
            busy     <= 1'b1;
            load_cnt <= '0;
            l1_ch    <= '0;
            l2_ch    <= '0;
          end
          LOAD: begin
            if (load_cnt == LC_W'(LOAD_CYC - 1)) begin
              state    <= L1_RUN;
              img_load <= 1'b0;
              l1_start <= 1'b1;
              wd       <= '0;
            end else begin
              load_cnt <= load_cnt + LC_W'(1);
            end
          end
          L1_RUN, L2_RUN: begin
            wd <= (act_cout || act_pool) ? '0 : wd + WD_W'(1);
            if (bad_event || wd_expired) begin
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              if (in_l1) l1_ch <= act_next;
              else       l2_ch <= act_next;
              if (act_pool) begin
                wd <= '0;
                if (in_l1) begin
                  state    <= L2_RUN;
                  l2_start <= 1'b1;
                end else begin
                  state     <= DONE;
                  done      <= 1'b1;
                  frame_cnt <= frame_cnt + 8'd1;
                end
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          ERR: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed testbench for cnn_layer_sequencer (built with TIMEOUT=16).
module tb_cnn_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic       l1_cout_done = 1'b0, l1_pool_done = 1'b0;
  logic       l2_cout_done = 1'b0, l2_pool_done = 1'b0;
  logic       img_load, l1_start, l2_start, busy, done, err;
  logic [4:0] l1_ch, l2_ch;
  logic [7:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  int l1s_cnt = 0, l2s_cnt = 0, done_cnt = 0;

  cnn_layer_sequencer #(.L1_CH(8), .L2_CH(16), .LOAD_CYC(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .l1_cout_done(l1_cout_done), .l1_pool_done(l1_pool_done),
    .l2_cout_done(l2_cout_done), .l2_pool_done(l2_pool_done),
    .img_load(img_load), .l1_start(l1_start), .l2_start(l2_start),
    .busy(busy), .done(done), .err(err),
    .l1_ch(l1_ch), .l2_ch(l2_ch), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle so each one-cycle pulse is seen exactly once.
  always @(negedge clk) begin
    if (l1_start) l1s_cnt++;
    if (l2_start) l2s_cnt++;
    if (done)     done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic c1, input logic p1, input logic c2, input logic p2);
    l1_cout_done = c1; l1_pool_done = p1; l2_cout_done = c2; l2_pool_done = p2;
    tick();
    l1_cout_done = 0; l1_pool_done = 0; l2_cout_done = 0; l2_pool_done = 0;
  endtask

  task automatic begin_frame();
    start = 1; tick(); start = 0;
    repeat (4) tick();
  endtask

  task automatic finish_l1();
    repeat (8) ev(1, 0, 0, 0);
    ev(0, 1, 0, 0);
  endtask

  task automatic drive_frame(input logic hold_start);
    start = 1; tick(); start = hold_start;
    repeat (4) tick();
    finish_l1();
    repeat (16) ev(0, 0, 1, 0);
    start = 0;
    ev(0, 0, 0, 1);
    tick();
  endtask

  task automatic do_abort();
    abort = 1; tick(); abort = 0;
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    rst = 0;
    tick(); tick();
    obs = {img_load, l1_start, l2_start, busy, done, err, l1_ch, l2_ch, frame_cnt};
    checks++;
    if (obs !== 23'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    #3 rst = 1;
    tick();
    obs = {img_load, l1_start, l2_start, busy, done, err, l1_ch, l2_ch, frame_cnt};
    checks++;
    if (obs !== 23'd0) begin failures++; $display("FAIL reset_release: got %h expected 0", obs); end
  endtask

  task automatic test_nominal();
    int hi = 0;
    int s1 = l1s_cnt, s2 = l2s_cnt, sd = done_cnt;
    start = 1; tick(); start = 0;
    repeat (4) begin if (img_load) hi++; tick(); end
    checks++;
    if (hi != 4) begin failures++; $display("FAIL load_cycles: got %0d expected 4", hi); end
    checks++;
    if ({img_load, l1_start, busy} !== 3'b011) begin
      failures++; $display("FAIL l1_start_pulse: got %b expected 011", {img_load, l1_start, busy});
    end
    ev(1, 0, 0, 0);
    checks++;
    if ({l1_start, l1_ch} !== {1'b0, 5'd1}) begin
      failures++; $display("FAIL l1_first_cout: got %b/%0d expected 0/1", l1_start, l1_ch);
    end
    repeat (7) ev(1, 0, 0, 0);
    checks++;
    if ({err, l1_ch} !== {1'b0, 5'd8}) begin
      failures++; $display("FAIL l1_count8: got err=%b ch=%0d expected 0/8", err, l1_ch);
    end
    ev(0, 1, 0, 0);
    checks++;
    if ({l2_start, l2_ch, err} !== {1'b1, 5'd0, 1'b0}) begin
      failures++; $display("FAIL l2_start_pulse: got %b/%0d/%b expected 1/0/0", l2_start, l2_ch, err);
    end
    repeat (16) ev(0, 0, 1, 0);
    checks++;
    if ({l2_start, l2_ch} !== {1'b0, 5'd16}) begin
      failures++; $display("FAIL l2_count16: got %b/%0d expected 0/16", l2_start, l2_ch);
    end
    ev(0, 0, 0, 1);
    checks++;
    if ({done, busy, frame_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      failures++; $display("FAIL done_state: got %b/%b/%0d expected 1/1/1", done, busy, frame_cnt);
    end
    tick();
    checks++;
    if ({done, busy, l1_ch, l2_ch} !== {1'b0, 1'b0, 5'd8, 5'd16}) begin
      failures++; $display("FAIL after_done: got %b/%b/%0d/%0d expected 0/0/8/16", done, busy, l1_ch, l2_ch);
    end
    checks++;
    if ((l1s_cnt - s1 != 1) || (l2s_cnt - s2 != 1) || (done_cnt - sd != 1)) begin
      failures++;
      $display("FAIL nominal_pulses: got l1s=%0d l2s=%0d done=%0d expected 1/1/1",
               l1s_cnt - s1, l2s_cnt - s2, done_cnt - sd);
    end
    exp_frames = 1;
  endtask

  task automatic test_early_pool();
    int s2 = l2s_cnt;
    begin_frame();
    repeat (5) ev(1, 0, 0, 0);
    ev(0, 1, 0, 0);
    checks++;
    if ({err, busy, l1_ch} !== {1'b1, 1'b0, 5'd5}) begin
      failures++; $display("FAIL early_pool_err: got %b/%b/%0d expected 1/0/5", err, busy, l1_ch);
    end
    start = 1; repeat (3) tick(); start = 0;
    checks++;
    if ({err, img_load, busy} !== 3'b100) begin
      failures++; $display("FAIL err_ignores_start: got %b expected 100", {err, img_load, busy});
    end
    checks++;
    if (l2s_cnt != s2) begin failures++; $display("FAIL early_no_l2_start: got %0d expected %0d", l2s_cnt, s2); end
    do_abort();
    checks++;
    if ({err, busy, l1_ch, l2_ch, frame_cnt} !== {1'b0, 1'b0, 5'd0, 5'd0, 8'(exp_frames)}) begin
      failures++; $display("FAIL abort_clears: got %b/%b/%0d/%0d/%0d expected 0/0/0/0/%0d",
                           err, busy, l1_ch, l2_ch, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_abort_priority();
    int s2 = l2s_cnt;
    begin_frame();
    repeat (8) ev(1, 0, 0, 0);
    abort = 1;
    ev(0, 1, 0, 0);
    abort = 0;
    tick();
    checks++;
    if ({busy, err, l1_ch, l2s_cnt - s2} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
      failures++; $display("FAIL abort_priority: got busy=%b err=%b ch=%0d l2s=%0d expected 0/0/0/0",
                           busy, err, l1_ch, l2s_cnt - s2);
    end
  endtask

  task automatic test_simultaneous();
    begin_frame();
    repeat (7) ev(1, 0, 0, 0);
    ev(0, 0, 1, 1);
    checks++;
    if ({l1_ch, l2_ch, err, l2_start} !== {5'd7, 5'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL ignore_l2_in_l1: got %0d/%0d/%b/%b expected 7/0/0/0", l1_ch, l2_ch, err, l2_start);
    end
    ev(1, 1, 0, 0);
    checks++;
    if ({l2_start, l1_ch, err} !== {1'b1, 5'd8, 1'b0}) begin
      failures++; $display("FAIL simultaneous: got %b/%0d/%b expected 1/8/0", l2_start, l1_ch, err);
    end
    repeat (16) ev(0, 0, 1, 0);
    ev(0, 0, 1, 0);
    checks++;
    if ({err, busy, l2_ch} !== {1'b1, 1'b0, 5'd16}) begin
      failures++; $display("FAIL cout_overflow: got %b/%b/%0d expected 1/0/16", err, busy, l2_ch);
    end
    do_abort();
  endtask

  task automatic test_timeout();
    begin_frame();
    finish_l1();
    repeat (15) tick();
    checks++;
    if ({err, busy} !== 2'b01) begin failures++; $display("FAIL timeout_15: got %b expected 01", {err, busy}); end
    tick();
    checks++;
    if ({err, busy} !== 2'b10) begin failures++; $display("FAIL timeout_16: got %b expected 10", {err, busy}); end
    start = 1; tick(); tick(); start = 0;
    checks++;
    if ({err, img_load, busy, frame_cnt} !== {3'b100, 8'(exp_frames)}) begin
      failures++; $display("FAIL timeout_start_ignored: got %b/%0d expected 100/%0d",
                           {err, img_load, busy}, frame_cnt, exp_frames);
    end
    do_abort();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL timeout_abort: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    logic [22:0] obs;
    int s1, s2, sd;
    begin_frame();
    repeat (3) ev(1, 0, 0, 0);
    checks++;
    if (l1_ch !== 5'd3) begin failures++; $display("FAIL mid_count: got %0d expected 3", l1_ch); end
    #3 rst = 0;
    #1;
    obs = {img_load, l1_start, l2_start, busy, done, err, l1_ch, l2_ch, frame_cnt};
    checks++;
    if (obs !== 23'd0) begin failures++; $display("FAIL async_reset: got %h expected 0", obs); end
    #2 rst = 1;
    tick();
    obs = {img_load, l1_start, l2_start, busy, done, err, l1_ch, l2_ch, frame_cnt};
    checks++;
    if (obs !== 23'd0) begin failures++; $display("FAIL mid_release: got %h expected 0", obs); end
    exp_frames = 0;
    s1 = l1s_cnt; s2 = l2s_cnt; sd = done_cnt;
    drive_frame(0);
    exp_frames = 1;
    checks++;
    if ({frame_cnt, err, busy} !== {8'd1, 2'b00} || (l1s_cnt - s1 != 1) || (l2s_cnt - s2 != 1) || (done_cnt - sd != 1)) begin
      failures++; $display("FAIL frame_after_reset: got cnt=%0d err=%b l1s=%0d l2s=%0d done=%0d expected 1/0/1/1/1",
                           frame_cnt, err, l1s_cnt - s1, l2s_cnt - s2, done_cnt - sd);
    end
  endtask

  task automatic test_back_to_back();
    int s1 = l1s_cnt, s2 = l2s_cnt, sd = done_cnt;
    for (int i = 0; i < 254; i++) drive_frame(1);
    checks++;
    if (frame_cnt !== 8'd255) begin failures++; $display("FAIL frame_cnt_255: got %0d expected 255", frame_cnt); end
    drive_frame(1);
    checks++;
    if (frame_cnt !== 8'd0) begin failures++; $display("FAIL frame_cnt_wrap: got %0d expected 0", frame_cnt); end
    checks++;
    if ((l1s_cnt - s1 != 255) || (l2s_cnt - s2 != 255) || (done_cnt - sd != 255)) begin
      failures++; $display("FAIL b2b_pulses: got l1s=%0d l2s=%0d done=%0d expected 255 each",
                           l1s_cnt - s1, l2s_cnt - s2, done_cnt - sd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_nominal();
    test_early_pool();
    test_abort_priority();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 SHALL have parameter L1_CH, default 8, number of layer-1 output channels per frame.
REQ-002 SHALL have parameter L2_CH, default 16, number of layer-2 output channels per frame.
REQ-003 SHALL have parameter LOAD_CYC, default 4, cycles img_load is held high per frame.
REQ-004 SHALL have parameter TIMEOUT, default 65535, idle cycles tolerated between layer events before error.
REQ-005 SHALL have ports: clk input 1 system clock; rst input 1 asynchronous active-low reset.
REQ-006 SHALL have ports: start input 1 frame request; abort input 1 cancel current frame.
REQ-007 SHALL have ports: l1_cout_done, l1_pool_done, l2_cout_done, l2_pool_done inputs 1 each; single-cycle layer event pulses.
REQ-008 SHALL have ports: img_load output 1 image memory load enable; l1_start, l2_start outputs 1 each; single-cycle layer start pulses.
REQ-009 SHALL have ports: busy output 1; done output 1 frame-complete pulse; err output 1 sticky error.
REQ-010 SHALL have ports: l1_ch output 5, l2_ch output 5, channels completed in current layer; frame_cnt output 8, frames completed.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, L1_RUN, L2_RUN, DONE, ERR; all outputs registered.
REQ-012 IDLE: start=1 -> LOAD next cycle; start in any other state SHALL be ignored (no queuing).
REQ-013 LOAD: img_load=1 for exactly LOAD_CYC cycles, then L1_RUN; l1_start=1 for the first L1_RUN cycle only.
REQ-014 L1_RUN: each l1_cout_done pulse SHALL increment l1_ch by 1.
REQ-015 L1_RUN: l1_pool_done with (post-increment) l1_ch==L1_CH -> L2_RUN; l2_start=1 first L2_RUN cycle.
REQ-016 L1_RUN: l1_pool_done with l1_ch!=L1_CH, or l1_cout_done when l1_ch already ==L1_CH -> ERR.
REQ-017 L2_RUN: same rules as REQ-014..016 using l2_* signals and L2_CH; success -> DONE.
REQ-018 Same-cycle cout_done and pool_done of one layer: count increment applied first, then pool_done check.
REQ-019 Events of the non-active layer (e.g. l2_cout_done in L1_RUN) SHALL be ignored.
REQ-020 DONE: one cycle; done=1, frame_cnt+1 (255 wraps to 0), then IDLE; l1_ch/l2_ch hold until next LOAD clears them.
REQ-021 Watchdog: counter cleared on state entry and on any active-layer event; reaching TIMEOUT in L1_RUN/L2_RUN -> ERR.
REQ-022 ERR: err=1, busy=0, no start pulses; exit only by abort or reset; frame_cnt unchanged.
REQ-023 abort=1 in any non-IDLE state -> IDLE next cycle, err cleared, l1_ch/l2_ch cleared, no done; abort has priority over all events.
REQ-024 busy=1 in LOAD, L1_RUN, L2_RUN, DONE; 0 otherwise.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, all outputs 0, counters 0, including mid-frame.
REQ-026 Release of rst SHALL take effect on next clk rising edge; no start pulse generated by release.

Verification
REQ-027 Nominal frame: start pulse, 8 l1_cout_done, l1_pool_done, 16 l2_cout_done, l2_pool_done -> img_load high 4 cycles, one l1_start, one l2_start, done one cycle, frame_cnt=1, busy falls.
REQ-028 Early pool: l1_pool_done after 5 l1_cout_done -> err=1 next cycle, l2_start never asserted; abort -> IDLE, err=0.
REQ-029 Simultaneous: 8th l1_cout_done and l1_pool_done same cycle -> L2_RUN, l2_start pulse, err=0.
REQ-030 Timeout with TIMEOUT=16: no events in L2_RUN for 16 cycles -> err=1; start ignored while in ERR.
REQ-031 Reset mid-L1_RUN with l1_ch=3 -> all outputs 0 immediately; new start runs full frame normally.
REQ-032 256 nominal frames -> frame_cnt wraps to 0; start during busy never causes second l1_start in a frame.
